// File: rtl/alu_ctrl_8bit_if.sv
// Command, response and external-ALU signal bundle for alu_ctrl_8bit.
// master = command issuer / response consumer / ALU; slave = the controller.
interface alu_ctrl_8bit_if;
    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 4;
    localparam int unsigned RW  = 2;
    localparam int unsigned FW  = 5;
    localparam int unsigned CW  = 16;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op;
    logic [RW-1:0]  cmd_rd;
    logic [RW-1:0]  cmd_rs;
    logic [RW-1:0]  cmd_rt;
    logic           cmd_imm_en;
    logic [DW-1:0]  cmd_imm;
    logic           cmd_wb;

    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_sel;
    logic [DW-1:0]  alu_y;
    logic           alu_carry;
    logic           alu_borrow;
    logic           alu_overflow;
    logic           alu_zero;
    logic           alu_negative;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [DW-1:0]  rsp_data;
    logic [FW-1:0]  rsp_flags;
    logic [CW-1:0]  cmd_count;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_en, cmd_imm, cmd_wb,
        output alu_y, alu_carry, alu_borrow, alu_overflow, alu_zero, alu_negative,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_flags, cmd_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm_en, cmd_imm, cmd_wb,
        input  alu_y, alu_carry, alu_borrow, alu_overflow, alu_zero, alu_negative,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_flags, cmd_count
    );
endinterface

// File: rtl/alu_ctrl_8bit.sv
// Sequencer for an external combinational 8-bit ALU: 4-entry register file,
// operand fetch at accept, one execute cycle, then a held response.
module alu_ctrl_8bit (
    input  logic           clk,
    input  logic           rst,
    alu_ctrl_8bit_if.slave bus
);
    localparam int unsigned DW   = 8;
    localparam int unsigned OPW  = 4;
    localparam int unsigned RW   = 2;
    localparam int unsigned CW   = 16;
    localparam int unsigned NREG = 4;
    localparam logic [OPW-1:0] OP_CMP = 4'hF;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    state_t         state_n;
    logic           accept;
    logic           capture;
    logic           done;
    logic           wr_en;
    logic [RW-1:0]  rd_q;
    logic           wb_q;
    logic [DW-1:0]  regs [NREG];

    // Next-state and per-state strobes
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        capture = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    accept  = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // CMP never writes back; r0 is hardwired to zero by never being written
    assign wr_en = capture && wb_q && (bus.alu_sel != OP_CMP) && (rd_q != RW'(0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_flags <= '0;
            bus.cmd_count <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            rd_q          <= '0;
            wb_q          <= 1'b0;
            regs          <= '{default: '0};
        end else begin
            state         <= state_n;
            bus.cmd_ready <= (state_n == IDLE);
            bus.rsp_valid <= (state_n == RESP);
            if (accept) begin
                bus.alu_a   <= regs[bus.cmd_rs];
                bus.alu_b   <= bus.cmd_imm_en ? bus.cmd_imm : regs[bus.cmd_rt];
                bus.alu_sel <= bus.cmd_op;
                rd_q        <= bus.cmd_rd;
                wb_q        <= bus.cmd_wb;
            end
            if (capture) begin
                bus.rsp_data  <= bus.alu_y;
                bus.rsp_flags <= {bus.alu_negative, bus.alu_zero, bus.alu_overflow,
                                  bus.alu_borrow, bus.alu_carry};
            end
            if (wr_en) begin
                regs[rd_q] <= bus.alu_y;
            end
            if (done) begin
                bus.cmd_count <= bus.cmd_count + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_8bit.sv
// Testbench for alu_ctrl_8bit: behavioural ALU, vector table with a response
// scoreboard, plus backpressure and reset-during-execute sequences.
module tb_alu_ctrl_8bit;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_INC = 4'h5;
    localparam logic [3:0] OP_CMP = 4'hF;
    localparam int NV = 20;

    typedef struct {
        logic [3:0] op;
        logic [1:0] rs;
        logic [1:0] rt;
        logic       imm_en;
        logic [7:0] imm;
        logic [1:0] rd;
        logic       wb;
        logic [7:0] exp_data;
        logic [4:0] exp_flags;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [4:0] flags;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cnt_exp;
    int   excl_viol;
    exp_t sb_q[$];
    vec_t vecs [NV];

    alu_ctrl_8bit_if bus ();

    alu_ctrl_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference combinational ALU
    logic [8:0] m_s;
    logic [7:0] m_y;
    logic       m_c;
    logic       m_b;
    logic       m_v;
    always_comb begin
        m_s = '0;
        m_y = '0;
        m_c = 1'b0;
        m_b = 1'b0;
        m_v = 1'b0;
        case (bus.alu_sel)
            OP_ADD: begin
                m_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                m_y = m_s[7:0];
                m_c = m_s[8];
                m_v = (bus.alu_a[7] == bus.alu_b[7]) && (m_y[7] != bus.alu_a[7]);
            end
            OP_SUB, OP_CMP: begin
                m_y = bus.alu_a - bus.alu_b;
                m_b = bus.alu_a < bus.alu_b;
                m_v = (bus.alu_a[7] != bus.alu_b[7]) && (m_y[7] != bus.alu_a[7]);
            end
            OP_AND: m_y = bus.alu_a & bus.alu_b;
            OP_OR:  m_y = bus.alu_a | bus.alu_b;
            OP_XOR: m_y = bus.alu_a ^ bus.alu_b;
            OP_INC: begin
                m_y = bus.alu_a + 8'h01;
                m_c = bus.alu_a == 8'hFF;
                m_v = bus.alu_a == 8'h7F;
            end
            default: m_y = '0;
        endcase
    end
    assign bus.alu_y        = m_y;
    assign bus.alu_carry    = m_c;
    assign bus.alu_borrow   = m_b;
    assign bus.alu_overflow = m_v;
    assign bus.alu_zero     = (m_y == 8'h00);
    assign bus.alu_negative = m_y[7];

    initial excl_viol = 0;
    always @(negedge clk) begin
        if (bus.cmd_ready && bus.rsp_valid) excl_viol = excl_viol + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                                input logic ie, input logic [7:0] imm, input logic [1:0] rd,
                                input logic wb, input logic [7:0] d, input logic [4:0] f);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.imm_en = ie; v.imm = imm;
        v.rd = rd; v.wb = wb; v.exp_data = d; v.exp_flags = f;
        return v;
    endfunction

    task automatic drive_cmd(input vec_t v);
        bus.cmd_op     = v.op;
        bus.cmd_rs     = v.rs;
        bus.cmd_rt     = v.rt;
        bus.cmd_imm_en = v.imm_en;
        bus.cmd_imm    = v.imm;
        bus.cmd_rd     = v.rd;
        bus.cmd_wb     = v.wb;
        bus.cmd_valid  = 1'b1;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb actual=empty required=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_data"}, 32'(bus.rsp_data), 32'(e.data));
            chk({tag, "_flags"}, 32'(bus.rsp_flags), 32'(e.flags));
        end
    endtask

    // Issue one command from a negedge and follow it through to IDLE
    task automatic run_cmd(input vec_t v);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_wait", 32'(bus.cmd_ready), 32'd1);
        drive_cmd(v);
        sb_q.push_back('{data: v.exp_data, flags: v.exp_flags});
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("exec_rv", 32'(bus.rsp_valid), 32'd0);
        chk("exec_cr", 32'(bus.cmd_ready), 32'd0);
        chk("exec_sel", 32'(bus.alu_sel), 32'(v.op));
        if (v.imm_en) chk("exec_b", 32'(bus.alu_b), 32'(v.imm));
        @(negedge clk);
        chk("lat_rv", 32'(bus.rsp_valid), 32'd1);
        if (bus.rsp_valid && bus.rsp_ready) pop_cmp("rsp");
        @(negedge clk);
        cnt_exp++;
        chk("count", 32'(bus.cmd_count), 32'(cnt_exp));
        chk("idle_cr", 32'(bus.cmd_ready), 32'd1);
        chk("idle_rv", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        checks  = 0;
        errors  = 0;
        cnt_exp = 0;

        for (int i = 0; i < 3; i++) vecs[i] = mk(OP_OR, 2'd1, 2'd2, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 5'b01000);
        vecs[3]  = mk(OP_OR,  2'd0, 2'd0, 1'b1, 8'h7F, 2'd1, 1'b1, 8'h7F, 5'b00000);
        vecs[4]  = mk(OP_INC, 2'd1, 2'd0, 1'b0, 8'h00, 2'd2, 1'b1, 8'h80, 5'b10100);
        vecs[5]  = mk(OP_OR,  2'd2, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h80, 5'b10000);
        vecs[6]  = mk(OP_OR,  2'd0, 2'd0, 1'b1, 8'hFF, 2'd1, 1'b1, 8'hFF, 5'b10000);
        vecs[7]  = mk(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h01, 2'd3, 1'b1, 8'h00, 5'b01001);
        vecs[8]  = mk(OP_OR,  2'd3, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 5'b01000);
        vecs[9]  = mk(OP_OR,  2'd0, 2'd0, 1'b1, 8'h10, 2'd1, 1'b1, 8'h10, 5'b00000);
        vecs[10] = mk(OP_CMP, 2'd1, 2'd0, 1'b1, 8'h20, 2'd1, 1'b1, 8'hF0, 5'b10010);
        vecs[11] = mk(OP_OR,  2'd1, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h10, 5'b00000);
        vecs[12] = mk(OP_SUB, 2'd1, 2'd0, 1'b1, 8'h10, 2'd0, 1'b0, 8'h00, 5'b01000);
        vecs[13] = mk(OP_AND, 2'd1, 2'd0, 1'b1, 8'hF0, 2'd0, 1'b0, 8'h10, 5'b00000);
        vecs[14] = mk(OP_XOR, 2'd1, 2'd1, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 5'b01000);
        vecs[15] = mk(OP_ADD, 2'd1, 2'd1, 1'b0, 8'h00, 2'd2, 1'b1, 8'h20, 5'b00000);
        vecs[16] = mk(OP_SUB, 2'd1, 2'd2, 1'b0, 8'h00, 2'd3, 1'b1, 8'hF0, 5'b10010);
        vecs[17] = mk(OP_ADD, 2'd3, 2'd0, 1'b1, 8'h90, 2'd0, 1'b0, 8'h80, 5'b10001);
        vecs[18] = mk(OP_OR,  2'd0, 2'd0, 1'b1, 8'hAA, 2'd0, 1'b1, 8'hAA, 5'b10000);
        vecs[19] = mk(OP_OR,  2'd0, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 5'b01000);

        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = '0;
        bus.cmd_rs     = '0;
        bus.cmd_rt     = '0;
        bus.cmd_rd     = '0;
        bus.cmd_imm_en = 1'b0;
        bus.cmd_imm    = '0;
        bus.cmd_wb     = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_cr",    32'(bus.cmd_ready), 32'd1);
        chk("rst_rv",    32'(bus.rsp_valid), 32'd0);
        chk("rst_cnt",   32'(bus.cmd_count), 32'd0);
        chk("rst_data",  32'(bus.rsp_data),  32'd0);
        chk("rst_flags", 32'(bus.rsp_flags), 32'd0);
        chk("rst_a",     32'(bus.alu_a),     32'd0);
        chk("rst_b",     32'(bus.alu_b),     32'd0);
        chk("rst_sel",   32'(bus.alu_sel),   32'd0);

        for (int i = 0; i < NV; i++) run_cmd(vecs[i]);

        // Backpressure: response held, new commands ignored
        bus.rsp_ready = 1'b0;
        v = mk(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h05, 2'd0, 1'b0, 8'h15, 5'b00000);
        drive_cmd(v);
        sb_q.push_back('{data: v.exp_data, flags: v.exp_flags});
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp_rv0", 32'(bus.rsp_valid), 32'd1);
        if (bus.rsp_valid) pop_cmp("bp");
        drive_cmd(mk(OP_OR, 2'd0, 2'd0, 1'b1, 8'hEE, 2'd1, 1'b1, 8'h00, 5'b00000));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rv",    32'(bus.rsp_valid), 32'd1);
            chk("bp_data",  32'(bus.rsp_data),  32'h15);
            chk("bp_flags", 32'(bus.rsp_flags), 32'd0);
            chk("bp_cr",    32'(bus.cmd_ready), 32'd0);
            chk("bp_cnt",   32'(bus.cmd_count), 32'(cnt_exp));
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        cnt_exp++;
        chk("bp_rel_cnt", 32'(bus.cmd_count), 32'(cnt_exp));
        chk("bp_rel_cr",  32'(bus.cmd_ready), 32'd1);
        chk("bp_rel_rv",  32'(bus.rsp_valid), 32'd0);
        run_cmd(mk(OP_OR, 2'd1, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h10, 5'b00000));

        // Reset while a write-back command is executing
        v = mk(OP_ADD, 2'd1, 2'd0, 1'b1, 8'h01, 2'd2, 1'b1, 8'h11, 5'b00000);
        drive_cmd(v);
        sb_q.push_back('{data: v.exp_data, flags: v.exp_flags});
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("rx_exec_rv", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        sb_q.delete();
        cnt_exp = 0;
        chk("rx_rv",    32'(bus.rsp_valid), 32'd0);
        chk("rx_cr",    32'(bus.cmd_ready), 32'd1);
        chk("rx_cnt",   32'(bus.cmd_count), 32'd0);
        chk("rx_data",  32'(bus.rsp_data),  32'd0);
        chk("rx_flags", 32'(bus.rsp_flags), 32'd0);
        chk("rx_sel",   32'(bus.alu_sel),   32'd0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rx_post_rv",  32'(bus.rsp_valid), 32'd0);
            chk("rx_post_cnt", 32'(bus.cmd_count), 32'd0);
        end
        run_cmd(mk(OP_OR, 2'd2, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 5'b01000));
        run_cmd(mk(OP_OR, 2'd1, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00, 5'b01000));

        chk("excl", 32'(excl_viol), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
